// File: rtl/nios2_cpu_mul_sequencer.sv
// Two-port round-robin sequencer for the Nios II three-partial-product
// 16x16 multiplier cell. Each granted 32x32 unsigned request makes one pass
// through the cell for the low word, or two passes for the high word.
// The result is returned on a valid/ready port tagged with the requester id.
module nios2_cpu_mul_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_hi,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_hi,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_id
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE1,
      ST_CAP1,
      ST_CAP2,
      ST_RESP
   } state_t;

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;          // port granted most recently
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        hi_q, hi_d;
   logic        id_q, id_d;
   logic [16:0] acc_hi_q, acc_hi_d;    // acc[48:32], carried into the high word
   logic [31:0] rsp_data_q, rsp_data_d;

   logic        grant0, grant1;
   logic [32:0] mid;
   logic [48:0] acc;
   logic [31:0] hi_word;

   // Round-robin arbitration, only in IDLE and never while reset is held
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset && state_q == ST_IDLE) begin
         grant0 = req0_valid & (~req1_valid | ptr_q);
         grant1 = req1_valid & (~req0_valid | ~ptr_q);
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Partial-product assembly; widths carry every bit, so no carry is lost
   always_comb begin
      mid     = {1'b0, cell_p2} + {1'b0, cell_p3};
      acc     = {17'b0, cell_p1} + {mid, 16'b0};
      hi_word = cell_p1 + {15'b0, acc_hi_q};
   end

   // Next-state, cell drive and operand capture
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      a_d        = a_q;
      b_d        = b_q;
      hi_d       = hi_q;
      id_d       = id_q;
      acc_hi_d   = acc_hi_q;
      rsp_data_d = rsp_data_q;
      cell_src1  = '0;
      cell_src2  = '0;
      cell_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant0) begin
               a_d     = req0_a;
               b_d     = req0_b;
               hi_d    = req0_hi;
               id_d    = 1'b0;
               ptr_d   = 1'b0;
               state_d = ST_ISSUE1;
            end else if (grant1) begin
               a_d     = req1_a;
               b_d     = req1_b;
               hi_d    = req1_hi;
               id_d    = 1'b1;
               ptr_d   = 1'b1;
               state_d = ST_ISSUE1;
            end
         end
         ST_ISSUE1: begin
            cell_src1 = a_q;
            cell_src2 = b_q;
            cell_en   = 1'b1;
            state_d   = ST_CAP1;
         end
         ST_CAP1: begin
            if (!hi_q) begin
               rsp_data_d = acc[31:0];
               state_d    = ST_RESP;
            end else begin
               // Second pass reuses p1 of the cell to form a_hi*b_hi
               acc_hi_d  = acc[48:32];
               cell_src1 = {16'h0, a_q[31:16]};
               cell_src2 = {16'h0, b_q[31:16]};
               cell_en   = 1'b1;
               state_d   = ST_CAP2;
            end
         end
         ST_CAP2: begin
            rsp_data_d = hi_word;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 1'b1;
         a_q        <= '0;
         b_q        <= '0;
         hi_q       <= 1'b0;
         id_q       <= 1'b0;
         acc_hi_q   <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         a_q        <= a_d;
         b_q        <= b_d;
         hi_q       <= hi_d;
         id_q       <= id_d;
         acc_hi_q   <= acc_hi_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = id_q;

endmodule

// File: doc/nios2_cpu_mul_sequencer.md
# nios2_cpu_mul_sequencer

Two-port sequencer and arbiter for the three-partial-product 16x16 multiplier cell in the Nios II CPU. It accepts 32x32 unsigned multiply requests from two requesters and grants them round-robin. For each granted request it drives the cell's source operands and enable over one or two passes, then assembles either the low or the high 32 bits of the 64-bit product from the registered partial products. The result is returned on a valid/ready response port tagged with the requester id.

## Interface
- No parameters; all widths are fixed: 32-bit operands, 16-bit cell halves, 32-bit partial products.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present on port 0 / 1.
- req0_ready / req1_ready  out  1  combinational accept strobe; high only in the grant cycle.
- req0_a, req0_b / req1_a, req1_b  in  32  unsigned operands.
- req0_hi / req1_hi  in  1  0 returns product[31:0]; 1 returns product[63:32].
- cell_src1, cell_src2  out  32  drive the cell's E_src1 / E_src2.
- cell_en  out  1  drives the cell's M_en.
- cell_p1, cell_p2, cell_p3  in  32  cell results: p1 = src1[15:0]*src2[15:0]; p2 = src1[15:0]*src2[31:16]; p3 = src1[31:16]*src2[15:0]. The cell registers them on the clk edge where cell_en=1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  32  result word.
- rsp_id  out  1  port that issued the request.

## Operation
- The state machine has five states: IDLE, ISSUE1, CAP1, CAP2, RESP.
- IDLE, arbitration:
  - If exactly one reqN_valid is high, assert its reqN_ready.
  - If both are high, grant the port that was not granted last. The last-grant pointer resets to 1, so port 0 wins the first tie.
  - On a grant, latch a, b, hi and id, update the pointer, and go to ISSUE1.
  - No port is granted outside IDLE.
- ISSUE1: cell_src1=a, cell_src2=b, cell_en=1. Go to CAP1.
- CAP1:
  - Compute mid = p2 + p3 (33 bits).
  - Compute acc = p1 + (mid << 16), kept at 49 bits so no carry is lost.
  - If hi=0: rsp_data <= acc[31:0], go to RESP.
  - If hi=1: in this same cycle drive cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1, then go to CAP2.
- CAP2: cell_p1 now holds a_hi*b_hi. rsp_data <= (cell_p1 + acc[48:32])[31:0], then go to RESP. This is exactly product[63:32].
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are stable.
  - On rsp_ready=1, go to IDLE.
  - While rsp_ready=0, hold all outputs and accept nothing.
- Outside the ISSUE1 and CAP1(hi=1) slots: cell_en=0, cell_src1=0, cell_src2=0. The cell's outputs then hold their values, and the block ignores them.
- Reset is asynchronous at any time:
  - State goes to IDLE, the pointer to 1.
  - rsp_valid, rsp_data, rsp_id, cell_en, cell_src1 and cell_src2 all go to 0.
  - Any in-flight operation is dropped with no response.
  - reqN_ready is 0 while reset is asserted.
- Arithmetic is unsigned only; signed forms are outside this block.

## Timing
- Request accepted in cycle T (reqN_valid & reqN_ready):
  - T+1: ISSUE1, cell_en=1.
  - T+2: CAP1.
  - hi=0: rsp_valid first high at T+3.
  - hi=1: second pass issued at T+2, CAP2 at T+3, rsp_valid first high at T+4.
- Response handshake completes in cycle R. IDLE is in R+1, and the earliest next grant is in R+1.
- Minimum issue interval: 4 cycles (lo) / 5 cycles (hi) with rsp_ready held high.
- reqN_ready depends combinationally on reqN_valid and the state only, never on rsp_ready.
- A requester may drop valid without being granted; no state is affected.

## Test plan
- Low product, port 0: a=0x0001_0003, b=0x0002_0005, hi=0 -> rsp_data=0x000B_000F, rsp_id=0; rsp_valid asserted 3 cycles after accept.
- High product, port 1: a=0x0001_0003, b=0x0002_0005, hi=1 -> rsp_data=0x0000_0002, rsp_id=1, 4 cycles after accept. Check that cell_en pulses in exactly 2 consecutive cycles.
- Carry check:
  - a=b=0xFFFF_FFFF, hi=1 -> 0xFFFF_FFFE.
  - a=b=0xFFFF_FFFF, hi=0 -> 0x0000_0001.
  - a=0x0000_FFFF, b=0xFFFF_FFFF, hi=1 -> 0x0000_FFFE.
- Arbitration: both ports valid continuously for 4 requests with rsp_ready=1 -> grant order 0,1,0,1, with rsp_id matching the grant order.
- Backpressure: hold rsp_ready=0 for 6 cycles in RESP with req0_valid high -> rsp_valid, rsp_data and rsp_id stable, req0_ready=0 throughout; the grant occurs the cycle after rsp_ready rises.
- Reset mid-operation: assert reset during CAP1 of a hi=1 request -> all outputs 0 immediately, no response issued; after release, a fresh request to port 0 completes correctly and wins a tie against port 1.
